// File: rtl/galaga_lib.sv
// Shared constants, types and helpers for the Galaga enemy projectile subsystem.
package galaga_lib;
  localparam int NPE_DEF     = 8;
  localparam int NS_DEF      = 16;
  localparam int IDW_DEF     = $clog2(NS_DEF);
  localparam int MAXG_DEF    = 2;
  localparam int AGE_MAX_DEF = 4;

  typedef logic [IDW_DEF-1:0] shooter_id_t;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/rr_multi_pick.sv
// Combinational round-robin picker: grants the first `count` set bits of cand,
// scanning upward from rr with wrap, and reports them in scan order.
module rr_multi_pick
  import galaga_lib::*;
#(
  parameter int NS   = NS_DEF,
  parameter int IDW  = $clog2(NS),
  parameter int MAXG = MAXG_DEF
) (
  input  logic [NS-1:0]             cand,
  input  logic [IDW-1:0]            rr,
  input  logic [IDW:0]              count,
  output logic [NS-1:0]             grant,
  output logic [IDW-1:0]            last,
  output logic [MAXG-1:0][IDW-1:0]  picks
);
  localparam int PW = (MAXG > 1) ? $clog2(MAXG) : 1;

  // Index arithmetic wraps naturally because NS is a power of two.
  always_comb begin
    logic [IDW-1:0] idx;
    logic [IDW:0]   n;
    grant = '0;
    last  = rr;
    picks = '0;
    n     = '0;
    idx   = rr;
    for (int k = 0; k < NS; k++) begin
      idx = rr + IDW'(k);
      if (cand[idx] && (n < count)) begin
        grant[idx]     = 1'b1;
        picks[PW'(n)]  = idx;
        last           = idx;
        n              = n + (IDW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/eship_proj_allocator.sv
// Enemy projectile slot allocator: round-robin grants of free slots to firing
// shooters, with aged pending requests that drop when they wait too long.
module eship_proj_allocator
  import galaga_lib::*;
#(
  parameter int NPE     = NPE_DEF,
  parameter int NS      = NS_DEF,
  parameter int IDW     = $clog2(NS),
  parameter int MAXG    = MAXG_DEF,
  parameter int AGE_MAX = AGE_MAX_DEF
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic [NS-1:0]        FireReq,
  input  logic [NPE-1:0]       EProjEn,
  output logic [NPE-1:0]       EProjActvt,
  output logic [NPE*IDW-1:0]   EProjShooter,
  output logic                 Dropped,
  output logic [7:0]           DropCount,
  output logic [IDW:0]         PendCount
);
  localparam int CW = IDW + 1;
  localparam int AW = $clog2(AGE_MAX + 2);
  localparam int SW = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int PW = (MAXG > 1) ? $clog2(MAXG) : 1;

  logic [NS-1:0]            pend, pend_nxt, cand, grant;
  logic [NS-1:0][AW-1:0]    age, age_nxt;
  logic [NPE-1:0]           resv, free, act;
  logic [IDW-1:0]           rr, last;
  logic [MAXG-1:0][IDW-1:0] picks;
  logic [MAXG-1:0][SW-1:0]  slot_of;
  logic [CW-1:0]            gcount, drop_cnt;
  logic [NPE*IDW-1:0]       shooter_nxt;
  logic [8:0]               dc_sum;

  // Reserved slots stay unavailable until the bank confirms them busy.
  assign cand = pend | FireReq;
  assign free = ~EProjEn & ~resv;

  always_comb begin
    int unsigned g;
    g = 32'(MAXG);
    if (popcount(64'(cand)) < g) g = popcount(64'(cand));
    if (popcount(64'(free)) < g) g = popcount(64'(free));
    gcount = Enable ? CW'(g) : '0;
  end

  rr_multi_pick #(.NS(NS), .IDW(IDW), .MAXG(MAXG)) u_pick (
    .cand  (cand),
    .rr    (rr),
    .count (gcount),
    .grant (grant),
    .last  (last),
    .picks (picks)
  );

  // The n-th granted shooter lands in the n-th lowest free slot.
  always_comb begin
    logic [CW-1:0] m;
    slot_of = '0;
    m       = '0;
    for (int i = 0; i < NPE; i++) begin
      if (free[i] && (m < gcount)) begin
        slot_of[PW'(m)] = SW'(i);
        m               = m + CW'(1);
      end
    end
  end

  always_comb begin
    act         = '0;
    shooter_nxt = EProjShooter;
    for (int n = 0; n < MAXG; n++) begin
      if (CW'(n) < gcount) begin
        act[slot_of[PW'(n)]]                         = 1'b1;
        shooter_nxt[slot_of[PW'(n)]*IDW +: IDW]      = picks[PW'(n)];
      end
    end
  end

  // Ungranted candidates either enter at age 1, grow older, or age out.
  always_comb begin
    pend_nxt = '0;
    age_nxt  = '0;
    drop_cnt = '0;
    for (int s = 0; s < NS; s++) begin
      if (cand[s] && !grant[s]) begin
        if (!pend[s]) begin
          pend_nxt[s] = 1'b1;
          age_nxt[s]  = AW'(1);
        end else if (age[s] >= AW'(AGE_MAX)) begin
          drop_cnt = drop_cnt + CW'(1);
        end else begin
          pend_nxt[s] = 1'b1;
          age_nxt[s]  = age[s] + AW'(1);
        end
      end
    end
  end

  assign dc_sum = {1'b0, DropCount} + 9'(drop_cnt);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      pend         <= '0;
      age          <= '0;
      resv         <= '0;
      rr           <= '0;
      EProjActvt   <= '0;
      EProjShooter <= '0;
      Dropped      <= 1'b0;
      DropCount    <= '0;
      PendCount    <= '0;
    end else if (Enable) begin
      pend         <= pend_nxt;
      age          <= age_nxt;
      resv         <= (resv & ~EProjEn) | act;
      if (gcount != '0) rr <= last + IDW'(1);
      EProjActvt   <= act;
      EProjShooter <= shooter_nxt;
      Dropped      <= (drop_cnt != '0);
      DropCount    <= dc_sum[8] ? 8'hFF : dc_sum[7:0];
      PendCount    <= CW'(popcount(64'(pend_nxt)));
    end else begin
      // Suspended: pending work is discarded silently, reservations keep tracking the bank.
      pend         <= '0;
      age          <= '0;
      resv         <= resv & ~EProjEn;
      EProjActvt   <= '0;
      Dropped      <= 1'b0;
      PendCount    <= '0;
    end
  end
endmodule

// File: tb/tb_eship_proj_allocator.sv
// Directed bench for eship_proj_allocator: a per-cycle vector table plus hand
// sequences for round-robin fairness, drop-count saturation and reset mid-grant.
module tb_eship_proj_allocator;
  import galaga_lib::*;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [15:0] FireReq;
  logic [7:0]  EProjEn;
  logic [7:0]  EProjActvt;
  logic [31:0] EProjShooter;
  logic        Dropped;
  logic [7:0]  DropCount;
  logic [4:0]  PendCount;

  int checks = 0;
  int errors = 0;

  always #5 frame_clk = ~frame_clk;

  eship_proj_allocator dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .Enable       (Enable),
    .FireReq      (FireReq),
    .EProjEn      (EProjEn),
    .EProjActvt   (EProjActvt),
    .EProjShooter (EProjShooter),
    .Dropped      (Dropped),
    .DropCount    (DropCount),
    .PendCount    (PendCount)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] fire;
    logic [7:0]  busy;
    logic [7:0]  act;
    logic [31:0] shooter;
    logic        drop;
    logic [7:0]  dcount;
    logic [4:0]  pend;
  } vec_t;

  vec_t vecs[21];

  // Drive inputs away from the edge, then sample 1 time unit after it.
  task automatic applyStimulus(input logic r, input logic e, input logic [15:0] f, input logic [7:0] b);
    Reset   = r;
    Enable  = e;
    FireReq = f;
    EProjEn = b;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int step, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step, got, want);
    end
  endtask

  initial begin
    shooter_id_t sid;
    Reset = 1'b1; Enable = 1'b0; FireReq = '0; EProjEn = '0;

    //          rst   en    fire      busy   act    shooter       drop  dcnt   pend
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h00, 32'h00000000, 1'b0, 8'd0, 5'd0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0001, 8'h00, 8'h01, 32'h00000000, 1'b0, 8'd0, 5'd0};
    vecs[2]  = '{1'b0, 1'b1, 16'h0001, 8'h00, 8'h02, 32'h00000000, 1'b0, 8'd0, 5'd0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h00, 32'h00000000, 1'b0, 8'd0, 5'd0};
    vecs[4]  = '{1'b0, 1'b1, 16'h000F, 8'h00, 8'h03, 32'h00000010, 1'b0, 8'd0, 5'd2};
    vecs[5]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 8'h0C, 32'h00003210, 1'b0, 8'd0, 5'd0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd0, 5'd0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0010, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd0, 5'd1};
    vecs[8]  = '{1'b0, 1'b1, 16'h0000, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd0, 5'd1};
    vecs[9]  = '{1'b0, 1'b1, 16'h0000, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd0, 5'd1};
    vecs[10] = '{1'b0, 1'b1, 16'h0000, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd0, 5'd1};
    vecs[11] = '{1'b0, 1'b1, 16'h0000, 8'hFF, 8'h00, 32'h00000000, 1'b1, 8'd1, 5'd0};
    vecs[12] = '{1'b0, 1'b1, 16'h0000, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd1, 5'd0};
    vecs[13] = '{1'b0, 1'b1, 16'h0028, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd1, 5'd2};
    vecs[14] = '{1'b0, 1'b0, 16'h0028, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd1, 5'd0};
    vecs[15] = '{1'b0, 1'b1, 16'h0000, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd1, 5'd0};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd0, 5'd0};
    vecs[17] = '{1'b0, 1'b1, 16'h0004, 8'hFF, 8'h00, 32'h00000000, 1'b0, 8'd0, 5'd1};
    vecs[18] = '{1'b0, 1'b1, 16'h0000, 8'hFE, 8'h01, 32'h00000002, 1'b0, 8'd0, 5'd0};
    vecs[19] = '{1'b0, 1'b1, 16'h00F0, 8'h00, 8'h06, 32'h00000542, 1'b0, 8'd0, 5'd2};
    vecs[20] = '{1'b0, 1'b1, 16'h0000, 8'h06, 8'h18, 32'h00076542, 1'b0, 8'd0, 5'd0};

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].fire, vecs[i].busy);
      checkOutput("actvt",    i, 32'(EProjActvt),   32'(vecs[i].act));
      checkOutput("shooter",  i, EProjShooter,      vecs[i].shooter);
      checkOutput("dropped",  i, 32'(Dropped),      32'(vecs[i].drop));
      checkOutput("dropcnt",  i, 32'(DropCount),    32'(vecs[i].dcount));
      checkOutput("pendcnt",  i, 32'(PendCount),    32'(vecs[i].pend));
    end

    // Fairness: all shooters fire, exactly one slot becomes free each cycle.
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'hFF);
    for (int k = 0; k <= 16; k++) begin
      logic [7:0] one;
      one = 8'h01 << (k % 8);
      applyStimulus(1'b0, 1'b1, 16'hFFFF, ~one);
      sid = EProjShooter[(k % 8) * 4 +: 4];
      checkOutput("rr_actvt",   k, 32'(EProjActvt), 32'(one));
      checkOutput("rr_shooter", k, 32'(sid),        32'(k % 16));
    end

    // Saturation: 16 requests drop every 5 cycles while all slots are busy.
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'hFF);
    for (int k = 1; k <= 80; k++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFF, 8'hFF);
      if (k == 75) checkOutput("sat_dc75", k, 32'(DropCount), 32'd240);
    end
    checkOutput("sat_dc80",   80, 32'(DropCount), 32'd255);
    checkOutput("sat_drop80", 80, 32'(Dropped),   32'd1);
    applyStimulus(1'b0, 1'b1, 16'h0007, 8'hFF);
    checkOutput("sat_pend81", 81, 32'(PendCount), 32'd3);
    for (int k = 82; k <= 84; k++) applyStimulus(1'b0, 1'b1, 16'h0000, 8'hFF);
    checkOutput("sat_pend84", 84, 32'(PendCount), 32'd3);
    checkOutput("sat_drop84", 84, 32'(Dropped),   32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 8'hFF);
    checkOutput("sat_drop85", 85, 32'(Dropped),   32'd1);
    checkOutput("sat_dc85",   85, 32'(DropCount), 32'd255);
    checkOutput("sat_pend85", 85, 32'(PendCount), 32'd0);

    // Reset arriving on the edge that would otherwise issue a grant.
    applyStimulus(1'b0, 1'b1, 16'h0008, 8'h00);
    checkOutput("rst_actvt_pre",   0, 32'(EProjActvt), 32'h01);
    checkOutput("rst_shooter_pre", 0, EProjShooter,    32'h00000003);
    applyStimulus(1'b1, 1'b1, 16'h0008, 8'h00);
    checkOutput("rst_actvt",   1, 32'(EProjActvt), 32'h00);
    checkOutput("rst_shooter", 1, EProjShooter,    32'h00000000);
    checkOutput("rst_dropcnt", 1, 32'(DropCount),  32'd0);
    checkOutput("rst_pendcnt", 1, 32'(PendCount),  32'd0);
    checkOutput("rst_dropped", 1, 32'(Dropped),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
